acc_cu_ext: RTL and testbench
=============================

# acc_cu_ext

Parametrised control unit for the accumulator CPU datapath: a Moore/Mealy FSM that sequences fetch, decode and execute over a 16-opcode instruction set. It adds configurable memory wait states, a two-phase INPUT handshake on `enter`, optional resume from HALT, and an instruction counter. It sits between the instruction register/flags and the datapath control inputs, replacing the 8-opcode control unit.

## Interface
- `MEM_LAT`, 0, extra wait cycles per memory access (0..15); each access lasts MEM_LAT+1 cycles
- `CNT_W`, 16, width of instruction counter
- `HALT_RESUME`, 0, 1 = an `enter` press leaves HALT and resumes fetch
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-low
- `enter`  in  1  user input strobe, held level
- `Aeq0`  in  1  accumulator == 0
- `Apos`  in  1  accumulator > 0
- `IR`  in  4  opcode field of instruction register
- `IRload, JMPmux, PCload, Meminst, MemWr, Aload, OutLoad, Halt`  out  1 each  datapath controls
- `Asel`  out  2  00 ALU, 01 memory, 10 input port, 11 IR immediate
- `ALUop`  out  3  000 add, 001 sub, 010 and, 011 or, 100 not, 101 inc, 110 dec, 111 pass
- `StateNo`  out  4  current state encoding
- `instr_count`  out  CNT_W  instructions decoded since reset

## Operation
- Opcodes: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 INPUT, 5 JZ, 6 JPOS, 7 HALT, 8 AND, 9 OR, A NOT, B INC, C DEC, D JMP, E LOADI, F OUT. Codes 0–7 are encoding-compatible with the previous unit.
- States and encodings: START 0000, FETCH 0001, DECODE 0010, EXEC 1000, IN_WAIT 1100, IN_REL 1101, HALT 1111.
- START: all controls 0. Next state: FETCH.
- FETCH: Meminst=0 for MEM_LAT+1 cycles. IRload and PCload are asserted in the last cycle only. Next state: DECODE.
- DECODE: Meminst=1 for one cycle. Increment `instr_count`, modulo 2^CNT_W. Branch:
  - INPUT → IN_WAIT
  - HALT → HALT
  - all other opcodes → EXEC
- EXEC, memory ops (LOAD, STORE): Meminst=1 for MEM_LAT+1 cycles. The final cycle carries the action: LOAD asserts Asel=01 and Aload; STORE asserts MemWr.
- EXEC, one-cycle ops:
  - ALU ops: Asel=00, Aload, ALUop per opcode (ADD 000, SUB 001, AND 010, OR 011, NOT 100, INC 101, DEC 110).
  - LOADI: Asel=11, Aload.
  - OUT: OutLoad.
  - JMP: JMPmux=1, PCload=1.
  - JZ: JMPmux=1; PCload=Aeq0.
  - JPOS: JMPmux=1; PCload=Apos.
- EXEC always returns to FETCH.
- IN_WAIT: Asel=10 is held. Aload=1 only in a cycle where enter=1, and that cycle moves to IN_REL. Otherwise stay.
- IN_REL: all controls 0. Stay while enter=1; move to FETCH when enter=0. One press loads exactly once.
- HALT: Halt=1. With HALT_RESUME=1, leave after enter goes high then low, reusing IN_REL without Aload; otherwise stay in HALT until reset.
- Unused state encodings go to START on the next edge, with all controls 0.
- Every control output not listed for a state is 0. No latches.

## Timing
- Reset: on a clock edge with reset=0, state←START, wait counter←0, instr_count←0.
- While reset=0, all control outputs are forced to 0 combinationally, so a STORE or PCload cut mid-access is never driven.
- Controls are combinational from state, wait counter, IR and flags. Flags are sampled only in the EXEC cycle.
- IR must be stable from the cycle after FETCH's last cycle through EXEC.
- Instruction length in cycles, with L = MEM_LAT+1:
  - ALU, jump, LOADI, OUT: L+2
  - LOAD, STORE: 2L+1
  - INPUT: L+1 + handshake + 1
- The wait counter is 4 bits; it resets to 0 on every state change.

## Structure
- Shared package `acc_cu_pkg`: state encodings, opcode constants, Asel and ALUop encodings.
- One natural sub-module, `acc_cu_waitcnt`: a load/count-down wait-state counter with a `last` output, used by FETCH and memory EXEC.

## Test plan
- Reset held 3 cycles mid-STORE with MEM_LAT=2 → MemWr is 0 throughout reset; StateNo=0000 after the edge; instr_count=0.
- Program LOADI, ADD, OUT, HALT with MEM_LAT=0 → ALU ops take 3 cycles each; OutLoad pulses once; Halt=1; instr_count=4.
- MEM_LAT=3, LOAD → FETCH lasts 4 cycles with a single IRload/PCload pulse; Aload occurs on EXEC cycle 4 with Asel=01.
- JZ with Aeq0=0, then with Aeq0=1 → JMPmux=1 in both; PCload=0 then 1. Same check for JPOS with Apos.
- INPUT with enter held high for 5 cycles → exactly one Aload with Asel=10; stays in IN_REL until enter=0, then FETCH.
- HALT_RESUME=1, HALT, enter pulse → FETCH resumes. HALT_RESUME=0 → Halt stays 1 for 50 cycles.

Source files
------------

// File: rtl/acc_cu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : acc_cu_pkg
//  Purpose  : Shared definitions for the accumulator CPU control unit:
//             state encodings, opcode values, Asel/ALUop encodings, the
//             control-output bundle and an opcode-to-ALU-function helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package acc_cu_pkg;

  // State encodings are externally visible on StateNo.
  typedef enum logic [3:0] {
    ST_START    = 4'b0000,
    ST_FETCH    = 4'b0001,
    ST_DECODE   = 4'b0010,
    ST_EXEC     = 4'b1000,
    ST_IN_WAIT  = 4'b1100,
    ST_IN_REL   = 4'b1101,
    ST_HALT     = 4'b1111
  } state_e;

  // Opcodes 0..7 keep the encodings of the previous 8-opcode unit.
  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_INPUT = 4'h4;
  localparam logic [3:0] OP_JZ    = 4'h5;
  localparam logic [3:0] OP_JPOS  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_AND   = 4'h8;
  localparam logic [3:0] OP_OR    = 4'h9;
  localparam logic [3:0] OP_NOT   = 4'hA;
  localparam logic [3:0] OP_INC   = 4'hB;
  localparam logic [3:0] OP_DEC   = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_LOADI = 4'hE;
  localparam logic [3:0] OP_OUT   = 4'hF;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_MEM = 2'b01;
  localparam logic [1:0] ASEL_IN  = 2'b10;
  localparam logic [1:0] ASEL_IMM = 2'b11;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_NOT  = 3'b100;
  localparam logic [2:0] ALU_INC  = 3'b101;
  localparam logic [2:0] ALU_DEC  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef struct packed {
    logic       irload;
    logic       jmpmux;
    logic       pcload;
    logic       meminst;
    logic       memwr;
    logic       aload;
    logic       outload;
    logic       halt;
    logic [1:0] asel;
    logic [2:0] aluop;
  } ctrl_t;

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT;
      OP_INC:  return ALU_INC;
      OP_DEC:  return ALU_DEC;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_cu_waitcnt.sv
`default_nettype none
// ============================================================================
//  Module   : acc_cu_waitcnt
//  Purpose  : Memory wait-state counter. Restarts from 0 whenever the owning
//             FSM changes state and advances once per cycle until it reaches
//             MEM_LAT, where it holds. `last` marks the final cycle of an
//             access of MEM_LAT+1 cycles.
//  Ports    : clock - rising-edge clock
//             reset - synchronous, active-low
//             clr   - state is changing on this edge; restart the count
//             last  - current cycle is the last cycle of the access
//  Revision : 1.0 - initial release
// ============================================================================
module acc_cu_waitcnt #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic last
);

  localparam logic [3:0] LAST_VAL = 4'(MEM_LAT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (cnt_q != LAST_VAL) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LAST_VAL);

endmodule
`default_nettype wire

// File: rtl/acc_cu_ext.sv
`default_nettype none
// ============================================================================
//  Module   : acc_cu_ext
//  Purpose  : Control unit for the accumulator CPU. Sequences fetch, decode
//             and execute over 16 opcodes with configurable memory wait
//             states, a two-phase INPUT handshake, optional HALT resume and
//             an instruction counter.
//  Ports    : clock, reset (sync, active-low)
//             enter       - user strobe (level)
//             Aeq0, Apos  - accumulator flags
//             IR          - opcode field
//             IRload, JMPmux, PCload, Meminst, MemWr, Aload, OutLoad, Halt,
//             Asel[1:0], ALUop[2:0] - datapath controls
//             StateNo[3:0]          - current state
//             instr_count[CNT_W-1:0] - instructions decoded since reset
//  Revision : 1.0 - initial release
// ============================================================================
module acc_cu_ext
  import acc_cu_pkg::*;
#(
  parameter int unsigned MEM_LAT     = 0,
  parameter int unsigned CNT_W       = 16,
  parameter bit          HALT_RESUME = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter,
  input  logic             Aeq0,
  input  logic             Apos,
  input  logic [3:0]       IR,
  output logic             IRload,
  output logic             JMPmux,
  output logic             PCload,
  output logic             Meminst,
  output logic             MemWr,
  output logic             Aload,
  output logic             OutLoad,
  output logic             Halt,
  output logic [1:0]       Asel,
  output logic [2:0]       ALUop,
  output logic [3:0]       StateNo,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             wait_clr;
  logic             wait_last;
  logic             is_mem_op;
  ctrl_t            ctl;

  assign is_mem_op = (IR == OP_LOAD) || (IR == OP_STORE);
  assign wait_clr  = (state_d != state_q);

  acc_cu_waitcnt #(
    .MEM_LAT (MEM_LAT)
  ) u_waitcnt (
    .clock (clock),
    .reset (reset),
    .clr   (wait_clr),
    .last  (wait_last)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_START;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    instr_count_d = instr_count_q;
    case (state_q)
      ST_START:   state_d = ST_FETCH;
      ST_FETCH:   if (wait_last) state_d = ST_DECODE;
      ST_DECODE: begin
        instr_count_d = instr_count_q + CNT_W'(1);
        if (IR == OP_INPUT)     state_d = ST_IN_WAIT;
        else if (IR == OP_HALT) state_d = ST_HALT;
        else                    state_d = ST_EXEC;
      end
      // One-cycle ops leave immediately; memory ops wait out the access.
      ST_EXEC:    if (!is_mem_op || wait_last) state_d = ST_FETCH;
      ST_IN_WAIT: if (enter) state_d = ST_IN_REL;
      ST_IN_REL:  if (!enter) state_d = ST_FETCH;
      // Resume shares IN_REL so the press must also be released first.
      ST_HALT:    if (HALT_RESUME && enter) state_d = ST_IN_REL;
      default:    state_d = ST_START;
    endcase
  end

  // Output logic
  always_comb begin
    ctl = '0;
    case (state_q)
      ST_FETCH: begin
        if (wait_last) begin
          ctl.irload = 1'b1;
          ctl.pcload = 1'b1;
        end
      end
      ST_DECODE: ctl.meminst = 1'b1;
      ST_EXEC: begin
        case (IR)
          OP_LOAD: begin
            ctl.meminst = 1'b1;
            if (wait_last) begin
              ctl.asel  = ASEL_MEM;
              ctl.aload = 1'b1;
            end
          end
          OP_STORE: begin
            ctl.meminst = 1'b1;
            ctl.memwr   = wait_last;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_INC, OP_DEC: begin
            ctl.asel  = ASEL_ALU;
            ctl.aload = 1'b1;
            ctl.aluop = alu_code(IR);
          end
          OP_LOADI: begin
            ctl.asel  = ASEL_IMM;
            ctl.aload = 1'b1;
          end
          OP_OUT: ctl.outload = 1'b1;
          OP_JMP: begin
            ctl.jmpmux = 1'b1;
            ctl.pcload = 1'b1;
          end
          OP_JZ: begin
            ctl.jmpmux = 1'b1;
            ctl.pcload = Aeq0;
          end
          OP_JPOS: begin
            ctl.jmpmux = 1'b1;
            ctl.pcload = Apos;
          end
          default: ;
        endcase
      end
      ST_IN_WAIT: begin
        ctl.asel  = ASEL_IN;
        ctl.aload = enter;
      end
      ST_HALT: ctl.halt = 1'b1;
      default: ;
    endcase
    // Kill everything during reset so an access cut short never writes.
    if (!reset) begin
      ctl = '0;
    end
  end

  assign IRload      = ctl.irload;
  assign JMPmux      = ctl.jmpmux;
  assign PCload      = ctl.pcload;
  assign Meminst     = ctl.meminst;
  assign MemWr       = ctl.memwr;
  assign Aload       = ctl.aload;
  assign OutLoad     = ctl.outload;
  assign Halt        = ctl.halt;
  assign Asel        = ctl.asel;
  assign ALUop       = ctl.aluop;
  assign StateNo     = state_q;
  assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_cu_ext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_cu_ext
//  Purpose  : Directed self-checking bench for acc_cu_ext. Three instances:
//             [0] MEM_LAT=0, [1] MEM_LAT=2, [2] MEM_LAT=3 with HALT_RESUME=1.
//             Control vector layout used for compares:
//             {IRload,JMPmux,PCload,Meminst,MemWr,Aload,OutLoad,Halt,Asel,ALUop}
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_cu_ext;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0;
  logic       aeq0  = 1'b0;
  logic       apos  = 1'b0;
  logic [3:0] ir    = 4'h0;

  logic        irload  [3];
  logic        jmpmux  [3];
  logic        pcload  [3];
  logic        meminst [3];
  logic        memwr   [3];
  logic        aload   [3];
  logic        outload [3];
  logic        halt    [3];
  logic [1:0]  asel    [3];
  logic [2:0]  aluop   [3];
  logic [3:0]  stno    [3];
  logic [15:0] icnt    [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    localparam bit          HR  = (g == 2);
    acc_cu_ext #(
      .MEM_LAT     (LAT),
      .CNT_W       (16),
      .HALT_RESUME (HR)
    ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .enter       (enter),
      .Aeq0        (aeq0),
      .Apos        (apos),
      .IR          (ir),
      .IRload      (irload[g]),
      .JMPmux      (jmpmux[g]),
      .PCload      (pcload[g]),
      .Meminst     (meminst[g]),
      .MemWr       (memwr[g]),
      .Aload       (aload[g]),
      .OutLoad     (outload[g]),
      .Halt        (halt[g]),
      .Asel        (asel[g]),
      .ALUop       (aluop[g]),
      .StateNo     (stno[g]),
      .instr_count (icnt[g])
    );
  end

  function automatic logic [12:0] ctrl(input int i);
    return {irload[i], jmpmux[i], pcload[i], meminst[i], memwr[i], aload[i],
            outload[i], halt[i], asel[i], aluop[i]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves all instances in START with reset released.
  task automatic do_reset();
    reset = 1'b0; enter = 1'b0; aeq0 = 1'b0; apos = 1'b0; ir = 4'h0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (stno[0] !== 4'h0 || icnt[0] !== 16'd0 || ctrl(0) !== 13'h0) begin
      errors++;
      $display("FAIL reset_state: state=%h count=%0d ctrl=%h, want 0/0/0", stno[0], icnt[0], ctrl(0));
    end
    // STORE on the MEM_LAT=2 instance: FETCH x3, DECODE, EXEC x3
    ir = 4'h1;
    tick(); tick(); tick();
    checks++;
    if (ctrl(1) !== 13'h1400) begin
      errors++;
      $display("FAIL store_fetch_last: ctrl=%h want 1400", ctrl(1));
    end
    tick(); tick();
    checks++;
    if (stno[1] !== 4'h8 || ctrl(1) !== 13'h0200) begin
      errors++;
      $display("FAIL store_exec1: state=%h ctrl=%h want 8/0200", stno[1], ctrl(1));
    end
    tick(); tick();
    checks++;
    if (stno[1] !== 4'h8 || memwr[1] !== 1'b1) begin
      errors++;
      $display("FAIL store_exec3: state=%h MemWr=%b want 8/1", stno[1], memwr[1]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ctrl(1) !== 13'h0) begin
      errors++;
      $display("FAIL reset_force: ctrl=%h want 0", ctrl(1));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (memwr[1] !== 1'b0 || stno[1] !== 4'h0 || icnt[1] !== 16'd0) begin
        errors++;
        $display("FAIL reset_hold%0d: MemWr=%b state=%h count=%0d want 0/0/0", k, memwr[1], stno[1], icnt[1]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_program();
    logic [3:0]  ops [4];
    logic [12:0] exp [3];
    int pulses;
    ops[0] = 4'hE; ops[1] = 4'h2; ops[2] = 4'hF; ops[3] = 4'h7;
    exp[0] = 13'h098; exp[1] = 13'h080; exp[2] = 13'h040;
    pulses = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      pulses += int'(outload[0]);
      checks++;
      if (stno[0] !== 4'h1 || ctrl(0) !== 13'h1400) begin
        errors++;
        $display("FAIL prog_fetch%0d: state=%h ctrl=%h want 1/1400", k, stno[0], ctrl(0));
      end
      ir = ops[k];
      tick();
      pulses += int'(outload[0]);
      checks++;
      if (stno[0] !== 4'h2 || ctrl(0) !== 13'h0200) begin
        errors++;
        $display("FAIL prog_decode%0d: state=%h ctrl=%h want 2/0200", k, stno[0], ctrl(0));
      end
      tick();
      pulses += int'(outload[0]);
      checks++;
      if (k < 3) begin
        if (stno[0] !== 4'h8 || ctrl(0) !== exp[k]) begin
          errors++;
          $display("FAIL prog_exec%0d: state=%h ctrl=%h want 8/%h", k, stno[0], ctrl(0), exp[k]);
        end
      end else if (stno[0] !== 4'hF || ctrl(0) !== 13'h020) begin
        errors++;
        $display("FAIL prog_halt: state=%h ctrl=%h want F/020", stno[0], ctrl(0));
      end
    end
    checks++;
    if (icnt[0] !== 16'd4 || pulses != 1) begin
      errors++;
      $display("FAIL prog_counts: count=%0d outpulses=%0d want 4/1", icnt[0], pulses);
    end
    // No resume configured: an enter press must not leave HALT.
    for (int c = 0; c < 50; c++) begin
      if (c == 10) enter = 1'b1;
      if (c == 13) enter = 1'b0;
      tick();
      checks++;
      if (stno[0] !== 4'hF || halt[0] !== 1'b1) begin
        errors++;
        $display("FAIL halt_stay%0d: state=%h Halt=%b want F/1", c, stno[0], halt[0]);
      end
    end
  endtask

  task automatic test_load_lat3();
    int pulses;
    int at;
    logic [12:0] e;
    pulses = 0;
    at = 0;
    do_reset();
    ir = 4'h0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (stno[2] !== 4'h1) begin
        errors++;
        $display("FAIL load_fetch%0d: state=%h want 1", c, stno[2]);
      end
      if (irload[2] === 1'b1 && pcload[2] === 1'b1) begin
        pulses++;
        at = c;
      end
    end
    checks++;
    if (pulses != 1 || at != 4) begin
      errors++;
      $display("FAIL load_fetch_pulse: pulses=%0d at=%0d want 1/4", pulses, at);
    end
    tick();
    checks++;
    if (stno[2] !== 4'h2 || ctrl(2) !== 13'h0200) begin
      errors++;
      $display("FAIL load_decode: state=%h ctrl=%h want 2/0200", stno[2], ctrl(2));
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      e = (c == 4) ? 13'h0288 : 13'h0200;
      checks++;
      if (stno[2] !== 4'h8 || ctrl(2) !== e) begin
        errors++;
        $display("FAIL load_exec%0d: state=%h ctrl=%h want 8/%h", c, stno[2], ctrl(2), e);
      end
    end
    tick();
    checks++;
    if (stno[2] !== 4'h1) begin
      errors++;
      $display("FAIL load_return: state=%h want 1", stno[2]);
    end
  endtask

  task automatic test_exec_ops();
    logic [3:0]  op  [14];
    logic        a0  [14];
    logic        ap  [14];
    logic [12:0] exp [14];
    op[0]  = 4'h2; a0[0]  = 0; ap[0]  = 0; exp[0]  = 13'h080;
    op[1]  = 4'h3; a0[1]  = 0; ap[1]  = 0; exp[1]  = 13'h081;
    op[2]  = 4'h8; a0[2]  = 0; ap[2]  = 0; exp[2]  = 13'h082;
    op[3]  = 4'h9; a0[3]  = 0; ap[3]  = 0; exp[3]  = 13'h083;
    op[4]  = 4'hA; a0[4]  = 0; ap[4]  = 0; exp[4]  = 13'h084;
    op[5]  = 4'hB; a0[5]  = 0; ap[5]  = 0; exp[5]  = 13'h085;
    op[6]  = 4'hC; a0[6]  = 0; ap[6]  = 0; exp[6]  = 13'h086;
    op[7]  = 4'hE; a0[7]  = 0; ap[7]  = 0; exp[7]  = 13'h098;
    op[8]  = 4'hF; a0[8]  = 0; ap[8]  = 0; exp[8]  = 13'h040;
    op[9]  = 4'hD; a0[9]  = 0; ap[9]  = 0; exp[9]  = 13'hC00;
    op[10] = 4'h5; a0[10] = 0; ap[10] = 1; exp[10] = 13'h800;
    op[11] = 4'h5; a0[11] = 1; ap[11] = 0; exp[11] = 13'hC00;
    op[12] = 4'h6; a0[12] = 1; ap[12] = 0; exp[12] = 13'h800;
    op[13] = 4'h6; a0[13] = 0; ap[13] = 1; exp[13] = 13'hC00;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      tick();
      checks++;
      if (stno[0] !== 4'h1) begin
        errors++;
        $display("FAIL ops_fetch%0d: state=%h want 1", k, stno[0]);
      end
      ir = op[k];
      aeq0 = 1'b0; apos = 1'b0;
      tick();
      aeq0 = a0[k]; apos = ap[k];
      tick();
      checks++;
      if (stno[0] !== 4'h8 || ctrl(0) !== exp[k]) begin
        errors++;
        $display("FAIL ops_exec op=%h: state=%h ctrl=%h want 8/%h", op[k], stno[0], ctrl(0), exp[k]);
      end
    end
    aeq0 = 1'b0; apos = 1'b0;
  endtask

  task automatic test_input();
    int loads;
    loads = 0;
    do_reset();
    tick();
    ir = 4'h4;
    tick();
    tick();
    checks++;
    if (stno[0] !== 4'hC || ctrl(0) !== 13'h010) begin
      errors++;
      $display("FAIL in_wait: state=%h ctrl=%h want C/010", stno[0], ctrl(0));
    end
    tick();
    checks++;
    if (stno[0] !== 4'hC || ctrl(0) !== 13'h010) begin
      errors++;
      $display("FAIL in_wait_hold: state=%h ctrl=%h want C/010", stno[0], ctrl(0));
    end
    enter = 1'b1;
    #1;
    loads += int'(aload[0]);
    checks++;
    if (ctrl(0) !== 13'h090) begin
      errors++;
      $display("FAIL in_press: ctrl=%h want 090", ctrl(0));
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      loads += int'(aload[0]);
      checks++;
      if (stno[0] !== 4'hD || ctrl(0) !== 13'h0) begin
        errors++;
        $display("FAIL in_rel%0d: state=%h ctrl=%h want D/0", k, stno[0], ctrl(0));
      end
    end
    enter = 1'b0;
    tick();
    checks++;
    if (stno[0] !== 4'h1 || loads != 1) begin
      errors++;
      $display("FAIL in_done: state=%h loads=%0d want 1/1", stno[0], loads);
    end
  endtask

  task automatic test_halt_resume();
    do_reset();
    ir = 4'h7;
    tick(); tick(); tick(); tick();
    tick();
    tick();
    checks++;
    if (stno[2] !== 4'hF || ctrl(2) !== 13'h020) begin
      errors++;
      $display("FAIL hr_halt: state=%h ctrl=%h want F/020", stno[2], ctrl(2));
    end
    tick(); tick();
    enter = 1'b1;
    #1;
    checks++;
    if (stno[2] !== 4'hF || halt[2] !== 1'b1) begin
      errors++;
      $display("FAIL hr_wait: state=%h Halt=%b want F/1", stno[2], halt[2]);
    end
    tick();
    checks++;
    if (stno[2] !== 4'hD || ctrl(2) !== 13'h0) begin
      errors++;
      $display("FAIL hr_rel: state=%h ctrl=%h want D/0", stno[2], ctrl(2));
    end
    tick();
    checks++;
    if (stno[2] !== 4'hD) begin
      errors++;
      $display("FAIL hr_rel_hold: state=%h want D", stno[2]);
    end
    enter = 1'b0;
    tick();
    checks++;
    if (stno[2] !== 4'h1 || icnt[2] !== 16'd1) begin
      errors++;
      $display("FAIL hr_resume: state=%h count=%0d want 1/1", stno[2], icnt[2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_load_lat3();
    test_exec_ops();
    test_input();
    test_halt_resume();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
